// File: rtl/gray_monitor.sv
// gray_monitor: consumes the upstream 3-bit Gray counter, converts it to binary,
// pulses Step/Wrap on legal advances, counts wraps (saturating) and latches the
// first illegal transition into an error FSM.
// Optional build macro GRAY_MONITOR_RECOVER_EN: when defined, the monitor leaves
// ERROR after RESYNC consecutive legal +1 steps; otherwise ERROR is sticky until
// Reset or Clear.
module gray_monitor #(
  parameter int WIDTH     = 3,
  parameter int WRAP_BITS = 4,
  parameter int RESYNC    = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Clear,
  input  logic [WIDTH-1:0]     GrayIn,
  input  logic                 OverflowIn,
  output logic [WIDTH-1:0]     Binary,
  output logic                 Step,
  output logic                 Wrap,
  output logic [WRAP_BITS-1:0] WrapCount,
  output logic                 Error,
  output logic [1:0]           ErrCode
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } monitorState_t;

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrBackward = 2'b01;
  localparam logic [1:0] ErrJump     = 2'b10;
  localparam logic [1:0] ErrOverflow = 2'b11;

  // A recovery threshold below one step would make ERROR meaningless.
  if (RESYNC < 1) begin : gResyncTooSmall
  end

  function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  monitorState_t        state;
  monitorState_t        nextState;
  logic [WIDTH-1:0]     prevGray;
  logic                 prevOverflow;
  logic [WIDTH-1:0]     curBin;
  logic [WIDTH-1:0]     prevBin;
  logic                 isHold;
  logic                 isUp;
  logic                 isDown;
  logic                 isWrap;
  logic                 nextStep;
  logic                 nextWrap;
  logic [WRAP_BITS-1:0] nextWrapCount;
  logic [1:0]           nextErrCode;

`ifdef GRAY_MONITOR_RECOVER_EN
  localparam int ResyncBits = $clog2(RESYNC + 1);
  logic [ResyncBits-1:0] resyncCount;
  logic [ResyncBits-1:0] nextResync;
`endif

  assign curBin  = grayToBin(GrayIn);
  assign prevBin = grayToBin(prevGray);
  assign isHold  = (GrayIn == prevGray);
  assign isUp    = (curBin == prevBin + WIDTH'(1));
  assign isDown  = (curBin == prevBin - WIDTH'(1));
  assign isWrap  = isUp && (prevBin == '1);
  assign Error   = (state == ERR);

  // Classify the transition from the previous sample and decide the next state and pulses.
  always_comb begin
    nextState     = state;
    nextStep      = 1'b0;
    nextWrap      = 1'b0;
    nextWrapCount = WrapCount;
    nextErrCode   = ErrCode;
`ifdef GRAY_MONITOR_RECOVER_EN
    nextResync    = '0;
`endif
    if (Clear) begin
      nextState     = IDLE;
      nextWrapCount = '0;
      nextErrCode   = ErrNone;
    end else begin
      case (state)
        IDLE: begin
          nextState = TRACK;
        end
        TRACK: begin
          if (!isHold && !isUp) begin
            nextErrCode = isDown ? ErrBackward : ErrJump;
            nextState   = ERR;
          end else if ((OverflowIn && !prevOverflow && !isWrap) || (isWrap && !OverflowIn)) begin
            nextErrCode = ErrOverflow;
            nextState   = ERR;
          end else if (isUp) begin
            nextStep = 1'b1;
            if (isWrap) begin
              nextWrap = 1'b1;
              if (WrapCount != '1) begin
                nextWrapCount = WrapCount + WRAP_BITS'(1);
              end
            end
          end
        end
        ERR: begin
`ifdef GRAY_MONITOR_RECOVER_EN
          if (isUp) begin
            if (int'(resyncCount) + 1 >= RESYNC) begin
              nextState = TRACK;
              nextStep  = 1'b1;
            end else begin
              nextResync = resyncCount + ResyncBits'(1);
            end
          end else if (isHold) begin
            nextResync = resyncCount;
          end
`endif
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  // Register state, outputs and the previous sample; Reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      prevGray     <= '0;
      prevOverflow <= 1'b0;
      Binary       <= '0;
      Step         <= 1'b0;
      Wrap         <= 1'b0;
      WrapCount    <= '0;
      ErrCode      <= ErrNone;
    end else begin
      state        <= nextState;
      prevGray     <= GrayIn;
      prevOverflow <= OverflowIn;
      Binary       <= curBin;
      Step         <= nextStep;
      Wrap         <= nextWrap;
      WrapCount    <= nextWrapCount;
      ErrCode      <= nextErrCode;
    end
  end

`ifdef GRAY_MONITOR_RECOVER_EN
  // Consecutive legal steps seen while in ERROR.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      resyncCount <= '0;
    end else begin
      resyncCount <= nextResync;
    end
  end
`endif

endmodule
